// File: rtl/logic_bist_pkg.sv
// Shared types and constants for the logic BIST controller and its optional MISR.
// The MISR is only instantiated when LOGIC_BIST_MISR_EN is defined.
package logic_bist_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // x^8 + x^6 + x^5 + x^4 + 1, with the x^8 term implied by the shift-out bit
   localparam logic [7:0] MISR_POLY = 8'h71;
   localparam logic [7:0] MISR_SEED = 8'hFF;

endpackage

// File: rtl/logic_bist_ctrl_if.sv
// Bundle between the BIST controller (master) and the CUT/user side (slave).
// The sig signature port exists only when LOGIC_BIST_MISR_EN is defined.
interface logic_bist_ctrl_if #(
   parameter int N_IN  = 3,
   parameter int CNT_W = 4
);
   logic              start;
   logic              f_in;
   logic [N_IN-1:0]   vec_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [CNT_W-1:0]  err_cnt;
   logic              first_fail_vld;
   logic [N_IN-1:0]   first_fail_vec;
`ifdef LOGIC_BIST_MISR_EN
   logic [7:0]        sig;
`endif

`ifdef LOGIC_BIST_MISR_EN
   modport master (
      input  start, f_in,
      output vec_out, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec, sig
   );
   modport slave (
      output start, f_in,
      input  vec_out, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec, sig
   );
`else
   modport master (
      input  start, f_in,
      output vec_out, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec
   );
   modport slave (
      output start, f_in,
      input  vec_out, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec
   );
`endif

endinterface

// File: rtl/logic_bist_misr.sv
// 8-bit multiple-input signature register; f_in response bits enter at bit 0.
// Instantiated by logic_bist_ctrl only under LOGIC_BIST_MISR_EN.
module logic_bist_misr
   import logic_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       shift_en,
   input  logic       din,
   output logic [7:0] sig
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= MISR_SEED;
      end else if (load) begin
         sig <= MISR_SEED;
      end else if (shift_en) begin
         sig <= {sig[6:0], din} ^ (sig[7] ? MISR_POLY : 8'h00);
      end
   end

endmodule

// File: rtl/logic_bist_ctrl.sv
// Exhaustive truth-table BIST: walks every CUT input vector, checks f_in against EXP_TT.
// Optional signature register enabled by defining LOGIC_BIST_MISR_EN.
module logic_bist_ctrl
   import logic_bist_pkg::*;
#(
   parameter int                 N_IN       = 3,
   parameter logic [2**N_IN-1:0] EXP_TT     = 8'hE8,
   parameter int                 SETTLE_CYC = 1,
   parameter int                 CNT_W      = 4
) (
   input logic                clk,
   input logic                rst_n,
   logic_bist_ctrl_if.master  bus
);

   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0]  LAST_VEC    = '1;
   localparam logic [CNT_W-1:0] ERR_MAX     = '1;

   state_t           state_q, state_d;
   logic [N_IN-1:0]  vec_q, vec_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             ffv_q, ffv_d;
   logic [N_IN-1:0]  ffvec_q, ffvec_d;
   logic             accept;
   logic             mismatch;

   assign accept   = bus.start && (state_q == IDLE || state_q == DONE);
   assign mismatch = bus.f_in != EXP_TT[vec_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffvec_q <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffvec_q <= ffvec_d;
      end
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = SETTLE;
               vec_d   = '0;
               cnt_d   = SETTLE_LOAD;
               err_d   = '0;
               ffv_d   = 1'b0;
               ffvec_d = '0;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) state_d = CHECK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) err_d = err_q + 1'b1;
               if (!ffv_q) begin
                  ffv_d   = 1'b1;
                  ffvec_d = vec_q;
               end
            end
            // The last vector parks vec_out so the run never wraps back to 0
            if (vec_q == LAST_VEC) begin
               state_d = DONE;
            end else begin
               state_d = SETTLE;
               vec_d   = vec_q + 1'b1;
               cnt_d   = SETTLE_LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.vec_out        = vec_q;
   assign bus.busy           = (state_q == SETTLE) || (state_q == CHECK);
   assign bus.done           = (state_q == DONE);
   assign bus.pass           = (state_q == DONE) && (err_q == '0);
   assign bus.err_cnt        = err_q;
   assign bus.first_fail_vld = ffv_q;
   assign bus.first_fail_vec = ffvec_q;

`ifdef LOGIC_BIST_MISR_EN
   logic_bist_misr u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .shift_en (state_q == CHECK),
      .din      (bus.f_in),
      .sig      (bus.sig)
   );
`endif

endmodule

// File: tb/tb_logic_bist_ctrl.sv
// Directed bench for logic_bist_ctrl: three instances (default, CNT_W=2, SETTLE_CYC=3)
// driven by a modelled 3-input CUT; the signature check runs under LOGIC_BIST_MISR_EN.
module tb_logic_bist_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] mode0;
   int         checks;
   int         errors;

   logic_bist_ctrl_if #(.N_IN(3), .CNT_W(4)) bus0 ();
   logic_bist_ctrl_if #(.N_IN(3), .CNT_W(2)) bus1 ();
   logic_bist_ctrl_if #(.N_IN(3), .CNT_W(4)) bus2 ();

   logic_bist_ctrl #(.N_IN(3), .EXP_TT(8'hE8), .SETTLE_CYC(1), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   logic_bist_ctrl #(.N_IN(3), .EXP_TT(8'hE8), .SETTLE_CYC(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   logic_bist_ctrl #(.N_IN(3), .EXP_TT(8'hE8), .SETTLE_CYC(3), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2));

   // CUT model: 0 = correct majority, 1 = output stuck at 0, 2 = inverted majority
   function automatic logic cut(input logic [1:0] m, input logic [2:0] v);
      logic maj;
      maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      case (m)
         2'd1:    return 1'b0;
         2'd2:    return ~maj;
         default: return maj;
      endcase
   endfunction

   assign bus0.f_in = cut(mode0, bus0.vec_out);
   assign bus1.f_in = cut(2'd2, bus1.vec_out);
   assign bus2.f_in = cut(2'd0, bus2.vec_out);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses start on dut0 for one cycle, then walks the 16-cycle run; returns at accept+16 +1ns.
   task automatic run0(input logic [3:0] exp_err, input logic exp_ffv, input logic [2:0] exp_ffvec,
                       input logic exp_pass, input bit spam_start);
      @(posedge clk); #1 bus0.start = 1'b1;
      @(posedge clk); #1 bus0.start = 1'b0;
      for (int c = 0; c < 16; c++) begin
         checks++;
         if (bus0.vec_out !== 3'(c / 2) || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
            errors++;
            $display("FAIL run_step c=%0d got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                     c, bus0.vec_out, bus0.busy, bus0.done, c / 2);
         end
         bus0.start = spam_start && (c % 3 == 1);
         @(posedge clk); #1;
      end
      bus0.start = 1'b0;
      checks++;
      if ({bus0.done, bus0.busy, bus0.vec_out} !== {1'b1, 1'b0, 3'd7}) begin
         errors++;
         $display("FAIL run_done got done=%b busy=%b vec=%0d want done=1 busy=0 vec=7",
                  bus0.done, bus0.busy, bus0.vec_out);
      end
      checks++;
      if ({bus0.pass, bus0.err_cnt, bus0.first_fail_vld, bus0.first_fail_vec}
          !== {exp_pass, exp_err, exp_ffv, exp_ffvec}) begin
         errors++;
         $display("FAIL run_result got pass=%b err=%0d ffv=%b ffvec=%0d want pass=%b err=%0d ffv=%b ffvec=%0d",
                  bus0.pass, bus0.err_cnt, bus0.first_fail_vld, bus0.first_fail_vec,
                  exp_pass, exp_err, exp_ffv, exp_ffvec);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({bus0.vec_out, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
           bus0.first_fail_vld, bus0.first_fail_vec} !== 13'd0) begin
         errors++;
         $display("FAIL %s got vec=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0d want all zero",
                  tag, bus0.vec_out, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
                  bus0.first_fail_vld, bus0.first_fail_vec);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #13;
      check_reset_values("reset_state");
`ifdef LOGIC_BIST_MISR_EN
      checks++;
      if (bus2.sig !== 8'hFF) begin
         errors++;
         $display("FAIL reset_sig got %h want ff", bus2.sig);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset_values("idle_hold");
   endtask

   task automatic test_majority;
      mode0 = 2'd0;
      run0(4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
   endtask

   task automatic test_stuck0;
      mode0 = 2'd1;
      run0(4'd4, 1'b1, 3'd3, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus0.done, bus0.err_cnt, bus0.first_fail_vec} !== {1'b1, 4'd4, 3'd3}) begin
         errors++;
         $display("FAIL done_hold got done=%b err=%0d ffvec=%0d want done=1 err=4 ffvec=3",
                  bus0.done, bus0.err_cnt, bus0.first_fail_vec);
      end
   endtask

   // Restart straight out of DONE: results clear and done drops on the accepting edge.
   task automatic test_back_to_back;
      mode0 = 2'd0;
      bus0.start = 1'b1;
      @(posedge clk); #1 bus0.start = 1'b0;
      checks++;
      if ({bus0.done, bus0.busy, bus0.vec_out, bus0.err_cnt, bus0.first_fail_vld}
          !== {1'b0, 1'b1, 3'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL rerun_accept got done=%b busy=%b vec=%0d err=%0d ffv=%b want 0 1 0 0 0",
                  bus0.done, bus0.busy, bus0.vec_out, bus0.err_cnt, bus0.first_fail_vld);
      end
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (bus0.done !== 1'b0) begin
         errors++;
         $display("FAIL rerun_early got done=%b want 0 at accept+15", bus0.done);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus0.done, bus0.pass, bus0.err_cnt} !== {1'b1, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL rerun_done got done=%b pass=%b err=%0d want 1 1 0",
                  bus0.done, bus0.pass, bus0.err_cnt);
      end
   endtask

   task automatic test_busy_start;
      mode0 = 2'd0;
      run0(4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
   endtask

   task automatic test_saturate;
      @(posedge clk); #1 bus1.start = 1'b1;
      @(posedge clk); #1 bus1.start = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      checks++;
      if ({bus1.done, bus1.pass, bus1.err_cnt, bus1.first_fail_vld, bus1.first_fail_vec}
          !== {1'b1, 1'b0, 2'd3, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL saturate got done=%b pass=%b err=%0d ffv=%b ffvec=%0d want 1 0 3 1 0",
                  bus1.done, bus1.pass, bus1.err_cnt, bus1.first_fail_vld, bus1.first_fail_vec);
      end
   endtask

   task automatic test_reset_mid;
      mode0 = 2'd1;
      @(posedge clk); #1 bus0.start = 1'b1;
      @(posedge clk); #1 bus0.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if ({bus0.vec_out, bus0.busy, bus0.first_fail_vld} !== {3'd5, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL mid_run_pos got vec=%0d busy=%b ffv=%b want 5 1 1",
                  bus0.vec_out, bus0.busy, bus0.first_fail_vld);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_abort");
      #2 rst_n = 1'b1;
      mode0 = 2'd0;
      run0(4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
   endtask

   task automatic test_settle3;
      @(posedge clk); #1 bus2.start = 1'b1;
      @(posedge clk); #1 bus2.start = 1'b0;
      for (int c = 0; c < 32; c++) begin
         checks++;
         if (bus2.vec_out !== 3'(c / 4) || bus2.done !== 1'b0) begin
            errors++;
            $display("FAIL settle3_step c=%0d got vec=%0d done=%b want vec=%0d done=0",
                     c, bus2.vec_out, bus2.done, c / 4);
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({bus2.done, bus2.pass, bus2.err_cnt} !== {1'b1, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL settle3_done got done=%b pass=%b err=%0d want 1 1 0",
                  bus2.done, bus2.pass, bus2.err_cnt);
      end
`ifdef LOGIC_BIST_MISR_EN
      // Hand-derived signature of seed ff over responses 0,0,0,1,0,1,1,1
      checks++;
      if (bus2.sig !== 8'h69) begin
         errors++;
         $display("FAIL misr_sig got %h want 69", bus2.sig);
      end
`endif
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      mode0      = 2'd0;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      test_reset();
      test_majority();
      test_stuck0();
      test_back_to_back();
      test_busy_start();
      test_saturate();
      test_reset_mid();
      test_settle3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
